// File: rtl/dmem_block_store_pkg.sv
// Shared sizes and types for the block-granular data memory and its helpers.
// Block geometry mirrors the data-cache line: 4 x 32-bit words, 4 offset bits.
package dmem_block_store_pkg;

  localparam int DC_BLOCK_BITS  = 128;
  localparam int DC_OFFSET_BITS = 4;
  localparam int DC_ADDR_BITS   = 32 - DC_OFFSET_BITS;
  localparam int DC_DEPTH_LOG2  = 10;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

  // Counter width able to hold the larger of two latency preloads.
  function automatic int cnt_width(input int lat_a, input int lat_b);
    int max_lat;
    max_lat = (lat_a > lat_b) ? lat_a : lat_b;
    return (max_lat < 2) ? 1 : $clog2(max_lat);
  endfunction

endpackage

// File: rtl/dmem_lat_counter.sv
// Loadable down-counter whose zero flag reflects the value being written this
// cycle, so a consumer can act on the same cycle the count reaches zero.
module dmem_lat_counter #(
  parameter int W = 3
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  assign zero = (count_d == '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/dmem_block_store.sv
// Fixed-latency whole-block backing store serving data-cache refills and
// writebacks over a level-held request / one-cycle completion pulse handshake.
module dmem_block_store
  import dmem_block_store_pkg::*;
#(
  parameter int BLOCK_BITS = DC_BLOCK_BITS,
  parameter int ADDR_BITS  = DC_ADDR_BITS,
  parameter int DEPTH_LOG2 = DC_DEPTH_LOG2,
  parameter int READ_LAT   = 4,
  parameter int WRITE_LAT  = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  memRen,
  input  logic                  memWen,
  input  logic [ADDR_BITS-1:0]  BlockAddr,
  input  logic [BLOCK_BITS-1:0] memDin,
  output logic [BLOCK_BITS-1:0] memDout,
  output logic                  memReadReady,
  output logic                  memWriteDone,
  output logic                  busy,
  output logic                  protoErr
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2,
    DONE    = 2'd3
  } state_e;

  localparam int CNT_W = cnt_width(READ_LAT, WRITE_LAT);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  state_e                state_q, state_d;
  op_e                   op_q;
  logic [DEPTH_LOG2-1:0] addr_idx, idx_q, rd_idx;
  logic [BLOCK_BITS-1:0] wdata_q;
  logic [BLOCK_BITS-1:0] mem [DEPTH];
  logic                  cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0]      cnt_load_val;
  logic                  rd_load, mem_we, set_err;
  logic                  unused_addr_hi;

  // Upper block-address bits alias onto the same entries.
  assign addr_idx       = BlockAddr[DEPTH_LOG2-1:0];
  assign unused_addr_hi = ^BlockAddr[ADDR_BITS-1:DEPTH_LOG2];

  assign cnt_load     = (state_q == IDLE) && (memRen ^ memWen);
  assign cnt_load_val = memRen ? CNT_W'(READ_LAT - 1) : CNT_W'(WRITE_LAT - 1);
  assign cnt_dec      = ((state_q == RD_WAIT) && memRen && !memWen) ||
                        ((state_q == WR_WAIT) && memWen && !memRen);

  dmem_lat_counter #(.W(CNT_W)) u_lat_counter (
    .clock    (clock),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every output of this block is defaulted first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    rd_load = 1'b0;
    rd_idx  = idx_q;
    mem_we  = 1'b0;
    set_err = 1'b0;
    case (state_q)
      IDLE: begin
        if (memRen && memWen) begin
          set_err = 1'b1;
        end else if (memRen || memWen) begin
          if (cnt_zero) begin
            // Unit latency: complete without a wait state, index not yet latched.
            state_d = DONE;
            rd_load = memRen;
            rd_idx  = addr_idx;
          end else begin
            state_d = memRen ? RD_WAIT : WR_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (!memRen || memWen) begin
          set_err = 1'b1;
          state_d = IDLE;
        end else if (cnt_zero) begin
          rd_load = 1'b1;
          state_d = DONE;
        end
      end
      WR_WAIT: begin
        if (!memWen || memRen) begin
          set_err = 1'b1;
          state_d = IDLE;
        end else if (cnt_zero) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        mem_we  = (op_q == OP_WR);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      op_q     <= OP_RD;
      idx_q    <= '0;
      wdata_q  <= '0;
      memDout  <= '0;
      protoErr <= 1'b0;
    end else begin
      if (cnt_load) begin
        op_q    <= memWen ? OP_WR : OP_RD;
        idx_q   <= addr_idx;
        wdata_q <= memDin;
      end
      if (rd_load) begin
        memDout <= mem[rd_idx];
      end
      if (set_err) begin
        protoErr <= 1'b1;
      end
    end
  end

  // NOTE: the array itself is never reset; reset only suppresses a pending commit.
  always_ff @(posedge clock) begin
    if (mem_we && !reset) begin
      mem[idx_q] <= wdata_q;
    end
  end

  assign busy         = (state_q != IDLE);
  assign memReadReady = (state_q == DONE) && (op_q == OP_RD);
  assign memWriteDone = (state_q == DONE) && (op_q == OP_WR);

endmodule

// File: tb/tb_dmem_block_store.sv
// Directed bench for dmem_block_store: stimulus queues expected completions,
// an independent monitor matches every pulse against them.
module tb_dmem_block_store;

  localparam int RL = 4;
  localparam int WL = 3;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         memRen = 1'b0;
  logic         memWen = 1'b0;
  logic [27:0]  BlockAddr = '0;
  logic [127:0] memDin = '0;
  logic [127:0] memDout;
  logic         memReadReady, memWriteDone, busy, protoErr;

  typedef struct {
    bit           is_wr;
    int           cyc;
    logic [127:0] data;
  } exp_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  localparam logic [127:0] D_BEEF = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
  localparam logic [127:0] D_1111 = 128'h11112222_33334444_55556666_77778888;
  localparam logic [127:0] D_AAAA = {16{8'hAA}};
  localparam logic [127:0] D_5555 = {16{8'h55}};
  localparam logic [127:0] D_3030 = {16{8'h30}};
  localparam logic [127:0] D_4040 = 128'h40404040_0BADF00D_40404040_0BADF00D;

  dmem_block_store #(.READ_LAT(RL), .WRITE_LAT(WL)) dut (
    .clock        (clock),
    .reset        (reset),
    .memRen       (memRen),
    .memWen       (memWen),
    .BlockAddr    (BlockAddr),
    .memDin       (memDin),
    .memDout      (memDout),
    .memReadReady (memReadReady),
    .memWriteDone (memWriteDone),
    .busy         (busy),
    .protoErr     (protoErr)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every completion pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (memReadReady || memWriteDone) begin
      if (sb.size() == 0) begin
        check("spurious_pulse", {memReadReady, memWriteDone}, 2'b00);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("pulse_kind", {memReadReady, memWriteDone}, e.is_wr ? 2'b01 : 2'b10);
        check("pulse_cycle", cyc, e.cyc);
        if (!e.is_wr) check("read_data", memDout, e.data);
      end
    end
  end

  // Controller-style request: held until its pulse, dropped the cycle after.
  // Called and returns #1 after a rising edge.
  task automatic do_req(input bit is_wr, input logic [27:0] addr,
                        input logic [127:0] din, input logic [127:0] exp_data);
    int lat, nbusy;
    bit seen;
    lat   = is_wr ? WL : RL;
    nbusy = 0;
    seen  = 1'b0;
    BlockAddr = addr;
    memDin    = din;
    memRen    = !is_wr;
    memWen    = is_wr;
    sb.push_back('{is_wr, cyc + lat, exp_data});
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clock);
      if (busy) nbusy++;
      if (memReadReady || memWriteDone) seen = 1'b1;
    end
    check("req_completed", seen, 1'b1);
    check("busy_cycles", nbusy, lat);
    @(posedge clock);
    #1;
    memRen = 1'b0;
    memWen = 1'b0;
    BlockAddr = 28'hFFFFFFF;
    memDin = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rst_memDout", memDout, '0);
    check("rst_ready", memReadReady, 1'b0);
    check("rst_done", memWriteDone, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_protoErr", protoErr, 1'b0);
    @(posedge clock);
    #1;

    // Preload, then refill from idx 0x010.
    do_req(1'b1, 28'h0000010, D_BEEF, '0);
    do_req(1'b1, 28'h0000040, D_4040, '0);
    do_req(1'b0, 28'h0000010, '0, D_BEEF);

    // Writeback to 0x20 must not disturb memDout; a read then returns it.
    do_req(1'b1, 28'h0000020, D_1111, '0);
    check("dout_hold_after_wr", memDout, D_BEEF);
    do_req(1'b0, 28'h0000020, '0, D_1111);

    // Aliasing: 0x405 and 0x005 share idx 0x005.
    do_req(1'b1, 28'h0000405, D_AAAA, '0);
    do_req(1'b0, 28'h0000005, '0, D_AAAA);

    // Both requests together: error flagged, nothing accepted.
    memRen = 1'b1;
    memWen = 1'b1;
    BlockAddr = 28'h0000010;
    repeat (3) @(negedge clock);
    check("both_protoErr", protoErr, 1'b1);
    check("both_busy", busy, 1'b0);
    @(posedge clock);
    #1;
    memRen = 1'b0;
    memWen = 1'b0;

    // Read aborted two cycles in: back to IDLE, no pulse, memDout kept.
    memRen = 1'b1;
    BlockAddr = 28'h0000010;
    repeat (2) begin
      @(posedge clock);
      #1;
    end
    memRen = 1'b0;
    @(negedge clock);
    check("abort_busy_before", busy, 1'b1);
    @(negedge clock);
    check("abort_idle", busy, 1'b0);
    check("abort_dout", memDout, D_AAAA);
    @(posedge clock);
    #1;

    // Reset clears sticky error; then a write is killed by reset two cycles in.
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rst2_protoErr", protoErr, 1'b0);
    @(posedge clock);
    #1;
    memWen = 1'b1;
    BlockAddr = 28'h0000020;
    memDin = D_5555;
    repeat (2) begin
      @(posedge clock);
      #1;
    end
    reset  = 1'b1;
    memWen = 1'b0;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("wr_rst_busy", busy, 1'b0);
    check("wr_rst_protoErr", protoErr, 1'b0);
    check("wr_rst_dout", memDout, '0);
    @(posedge clock);
    #1;
    do_req(1'b0, 28'h0000020, '0, D_1111);

    // Back-to-back writeback then refill, each held until its pulse.
    do_req(1'b1, 28'h0000030, D_3030, '0);
    do_req(1'b0, 28'h0000040, '0, D_4040);
    repeat (6) @(negedge clock);
    check("final_busy", busy, 1'b0);
    check("final_protoErr", protoErr, 1'b0);
    check("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
